// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 4-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic             found,
  output sel_t             idx
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  sel_t               off;

  // Rotate so ptr lands at bit 0, find lowest set bit, then rotate the index back.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: N_REQ];
    found   = 1'b0;
    off     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
    idx = ptr + off;
  end

endmodule : rr_pick

// File: rtl/mux4_rr_arbiter.sv
// Packet-holding round-robin arbiter driving a shared 4:1 data mux.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req_valid,
  input  logic [4*DATA_W-1:0]     req_data,
  input  logic [3:0]              req_last,
  output logic [3:0]              req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [3:0]              grant,
  output logic [1:0]              sel,
  output logic                    busy
);

  arb_state_t       state_q, state_d;
  sel_t             ptr_q, ptr_d;
  sel_t             sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;

  logic pick_found;
  sel_t pick_idx;
  logic in_grant;
  logic xfer;

  rr_pick u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Zero-latency datapath: mux selected by the registered owner index.
  always_comb begin
    in_grant  = (state_q == GRANT);
    out_data  = req_data[32'(sel_q) * DATA_W +: DATA_W];
    out_last  = req_last[sel_q];
    out_valid = in_grant & req_valid[sel_q];
    req_ready = (in_grant & out_ready) ? grant_q : '0;
    xfer      = out_valid & out_ready;
  end

  // Next-state: arbitrate in IDLE, hold the owner until its last beat is accepted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (xfer && out_last) begin
          state_d = IDLE;
          ptr_d   = sel_q + SEL_W'(1);
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and arbitration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule : mux4_rr_arbiter

// File: tb/tb_mux4_rr_arbiter.sv
// Directed vector bench for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;

  localparam int unsigned DATA_W = 8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        busy;

  mux4_rr_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic [31:0] rd;
    logic        ord;
    logic [3:0]  g;
    logic [1:0]  s;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
    logic [3:0]  rr;
    logic        b;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(logic r, logic [3:0] rv, logic [3:0] rl, logic [7:0] d0,
                              logic ord, logic [3:0] g, logic [1:0] s, logic ov,
                              logic [7:0] od, logic ol, logic [3:0] rr, logic b);
    vec_t v;
    v.rst_n = r;  v.rv = rv; v.rl = rl; v.rd = {8'hD3, 8'hC2, 8'hB1, d0};
    v.ord = ord;  v.g = g;   v.s = s;   v.ov = ov; v.od = od; v.ol = ol;
    v.rr = rr;    v.b = b;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic chk_regs(input int idx, input logic [3:0] g, input logic [1:0] s,
                          input logic b);
    chk("grant", idx, 32'(grant), 32'(g));
    chk("sel",   idx, 32'(sel),   32'(s));
    chk("busy",  idx, 32'(busy),  32'(b));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; req_last = '0; req_data = '0; out_ready = 1'b1;

    //              rst  rv    rl    d0     ord  g     s  ov od     ol rr    b
    vecs[0]  = mk(0, 4'hF, 4'h0, 8'h11, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 0);
    vecs[1]  = mk(1, 4'hF, 4'h0, 8'h11, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 0);
    vecs[2]  = mk(1, 4'hF, 4'h0, 8'h11, 1, 4'h1, 0, 1, 8'h11, 0, 4'h1, 1);
    vecs[3]  = mk(1, 4'hF, 4'h0, 8'h22, 1, 4'h1, 0, 1, 8'h22, 0, 4'h1, 1);
    vecs[4]  = mk(1, 4'hF, 4'h1, 8'h33, 1, 4'h1, 0, 1, 8'h33, 1, 4'h1, 1);
    vecs[5]  = mk(1, 4'hF, 4'hF, 8'h33, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 0);
    vecs[6]  = mk(1, 4'hF, 4'hF, 8'h33, 1, 4'h2, 1, 1, 8'hB1, 1, 4'h2, 1);
    vecs[7]  = mk(1, 4'hF, 4'hF, 8'h33, 1, 4'h0, 1, 0, 8'h00, 0, 4'h0, 0);
    vecs[8]  = mk(1, 4'hF, 4'hF, 8'h33, 1, 4'h4, 2, 1, 8'hC2, 1, 4'h4, 1);
    vecs[9]  = mk(1, 4'hF, 4'hF, 8'h33, 1, 4'h0, 2, 0, 8'h00, 0, 4'h0, 0);
    vecs[10] = mk(1, 4'hF, 4'hF, 8'h33, 1, 4'h8, 3, 1, 8'hD3, 1, 4'h8, 1);
    vecs[11] = mk(1, 4'hF, 4'hF, 8'h33, 1, 4'h0, 3, 0, 8'h00, 0, 4'h0, 0);
    vecs[12] = mk(1, 4'hF, 4'hF, 8'h33, 1, 4'h1, 0, 1, 8'h33, 1, 4'h1, 1);
    vecs[13] = mk(1, 4'h0, 4'h0, 8'h33, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 0);
    vecs[14] = mk(1, 4'h4, 4'h0, 8'h33, 0, 4'h0, 0, 0, 8'h00, 0, 4'h0, 0);
    vecs[15] = mk(1, 4'h6, 4'h0, 8'h33, 0, 4'h4, 2, 1, 8'hC2, 0, 4'h0, 1);
    vecs[16] = mk(1, 4'h6, 4'h0, 8'h33, 0, 4'h4, 2, 1, 8'hC2, 0, 4'h0, 1);
    vecs[17] = mk(1, 4'h6, 4'h0, 8'h33, 0, 4'h4, 2, 1, 8'hC2, 0, 4'h0, 1);
    vecs[18] = mk(1, 4'h6, 4'h0, 8'h33, 0, 4'h4, 2, 1, 8'hC2, 0, 4'h0, 1);
    vecs[19] = mk(1, 4'h6, 4'h4, 8'h33, 1, 4'h4, 2, 1, 8'hC2, 1, 4'h4, 1);
    vecs[20] = mk(1, 4'h0, 4'h0, 8'h33, 1, 4'h0, 2, 0, 8'h00, 0, 4'h0, 0);
    vecs[21] = mk(1, 4'h9, 4'h0, 8'h33, 1, 4'h0, 2, 0, 8'h00, 0, 4'h0, 0);
    vecs[22] = mk(1, 4'h9, 4'h0, 8'h33, 1, 4'h8, 3, 1, 8'hD3, 0, 4'h8, 1);
    vecs[23] = mk(1, 4'h1, 4'h0, 8'h33, 1, 4'h8, 3, 0, 8'h00, 0, 4'h8, 1);
    vecs[24] = mk(1, 4'h1, 4'h0, 8'h33, 1, 4'h8, 3, 0, 8'h00, 0, 4'h8, 1);
    vecs[25] = mk(1, 4'h9, 4'h8, 8'h33, 1, 4'h8, 3, 1, 8'hD3, 1, 4'h8, 1);
    vecs[26] = mk(1, 4'h1, 4'h0, 8'h33, 1, 4'h0, 3, 0, 8'h00, 0, 4'h0, 0);
    vecs[27] = mk(1, 4'h0, 4'h0, 8'h33, 1, 4'h1, 0, 0, 8'h00, 0, 4'h1, 1);

    // Each vector is applied after a falling edge and checked just before the rising edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; req_valid = vecs[i].rv; req_last = vecs[i].rl;
      req_data = vecs[i].rd; out_ready = vecs[i].ord;
      #2;
      chk_regs(i, vecs[i].g, vecs[i].s, vecs[i].b);
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
      chk("req_ready", i, 32'(req_ready), 32'(vecs[i].rr));
      if (vecs[i].ov) begin
        chk("out_data", i, 32'(out_data), 32'(vecs[i].od));
        chk("out_last", i, 32'(out_last), 32'(vecs[i].ol));
      end
    end

    // Async reset mid-packet while requester 1 holds the grant.
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'h0; req_last = 4'h0; out_ready = 1'b0;
    #2;
    chk_regs(100, 4'h0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'h2;
    @(negedge clk);
    chk_regs(101, 4'h2, 2'd1, 1'b1);
    chk("out_valid", 101, 32'(out_valid), 32'd1);
    chk("out_data",  101, 32'(out_data),  32'hB1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs(102, 4'h0, 2'd0, 1'b0);
    chk("out_valid", 102, 32'(out_valid), 32'd0);
    chk("req_ready", 102, 32'(req_ready), 32'd0);

    // Restart arbitrates freshly with requester 0 on top.
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'h3; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_regs(103, 4'h1, 2'd0, 1'b1);
    chk("req_ready", 103, 32'(req_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux4_rr_arbiter

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 data multiplexer between four packet-oriented requesters. It selects a winner, drives the mux select and the per-requester grant, and holds the grant for a whole packet (until the beat flagged `last` is accepted downstream). It sits between four upstream sources and a single downstream consumer, and is the sequencing layer for the 4:1 mux datapath.

## Interface
Parameters:
- `DATA_W`, 8: payload width per requester.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 4: requester i has a beat available.
- `req_data` in 4*DATA_W: payload; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last` in 4: beat from requester i is the final beat of its packet.
- `req_ready` out 4: beat from requester i accepted this cycle (one-hot or zero).
- `out_valid` out 1: muxed beat valid.
- `out_data` out DATA_W: muxed payload.
- `out_last` out 1: muxed last flag.
- `out_ready` in 1: downstream accepts beat.
- `grant` out 4: one-hot owner of the mux, or zero when idle.
- `sel` out 2: binary index of the current owner; drives the mux select.
- `busy` out 1: high while in GRANT.

## Operation
- States: IDLE, GRANT.
- Priority pointer `ptr` (2 bits): the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if any `req_valid` is set, the first set index in search order becomes the winner. On the next edge `sel` is set to the winner, `grant` to one-hot(winner), and the state moves to GRANT. If no request is set, the block stays in IDLE.
- GRANT, combinational outputs:
  - `out_valid = req_valid[sel]`
  - `out_data = req_data[sel]`
  - `out_last = req_last[sel]`
  - `req_ready[sel] = out_ready` (all other bits 0)
- Transfer occurs when `out_valid & out_ready`.
- Transfer with `out_last` = 1: at the next edge the state goes to IDLE, `ptr` becomes sel+1 (mod 4) and `grant` becomes 0.
- Transfer with `out_last` = 0: the grant is held.
- Owner drops `req_valid` mid-packet: the grant is held and `out_valid` is 0. There is no timeout and no preemption.
- Requests from other requesters never affect an active grant.
- IDLE outputs: `out_valid` = 0, `req_ready` = 0, `out_data` = `req_data[sel]`; the value of `out_data` is don't-care.
- Single-beat packets are legal: a beat with `last` = 1 on its first transfer.

## Timing
- Reset values, applied immediately on `rst_n` low: state IDLE, `ptr` 0, `sel` 0, `grant` 0, `busy` 0, `out_valid` 0, `req_ready` 0.
- Reset mid-packet aborts the packet with no cleanup. Restart after reset is treated as fresh arbitration with requester 0 at top priority.
- Arbitration latency: request seen in IDLE at edge N, grant visible after edge N; the first beat can transfer in cycle N+1.
- Bubble: one idle cycle between packets. After the `last` transfer there is one cycle in IDLE before the next grant, even if requests are pending. Maximum utilisation is therefore L/(L+1) for L-beat packets.
- Fairness: every continuously requesting source is granted within 3 packets of other sources.
- Data path from `req_*` to `out_*` is purely combinational within a cycle (zero-latency mux); `sel` and `grant` are registered.
- `out_ready` is permitted to depend on `out_valid`. `req_ready` depends on `out_ready` combinationally, and there is no reverse path.

## Structure
- Package `mux_arb_pkg`:
  - `N_REQ = 4`
  - `SEL_W = 2`
  - typedef `arb_state_t` enum {IDLE, GRANT}
  - typedef `sel_t` logic[SEL_W-1:0]
- Sub-module `rr_pick`: combinational. Inputs `req[3:0]` and `ptr[1:0]`; outputs `found` and `idx[1:0]`. It rotates, finds the first set bit, and un-rotates.
- The top holds the FSM, the `ptr`/`sel`/`grant` registers, and the data mux. The mux is built from the existing 2:1 mux cells or an equivalent indexed select.

## Test plan
- Reset: hold `rst_n` = 0 with all `req_valid` = 1 -> `grant` = 0, `out_valid` = 0, `req_ready` = 0, `sel` = 0. Release -> `grant` = 4'b0001 one cycle later.
- Single packet: req0 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33) with `out_ready` = 1 -> `out_data` 0x11/0x22/0x33 on consecutive cycles, `grant` = 0 for the following cycle, then `ptr` = 1.
- Rotation: all four request continuous 1-beat packets -> grants go 0,1,2,3,0 with a one-cycle IDLE gap between each.
- Backpressure: req2 owns the grant, `out_ready` = 0 for 4 cycles -> `out_valid` = 1, `req_ready` = 0, and `out_data` is stable; no grant change when req1 asserts meanwhile.
- Owner gap: req3 drops `req_valid` for 2 cycles mid-packet while req0 is requesting -> `grant` stays 4'b1000, `out_valid` = 0, and the packet resumes.
- Async reset mid-packet: assert `rst_n` = 0 between edges while req1 holds the grant -> outputs return to reset values before the next edge.
